// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 19-bit memory port among NREQ
// bus masters. Each transaction runs IDLE -> ISSUE -> RESP -> DONE, and a
// per-request lock lets one master keep priority for at most MAX_LOCK grants.
module mem_arbiter #(
  parameter int NREQ     = 3,
  parameter int MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*19-1:0]   req_addr,
  input  logic [NREQ*19-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_done,
  output logic [18:0]          req_rdata,
  output logic [1:0]           gnt_id,
  output logic                 busy,
  output logic                 mem_valid,
  output logic                 mem_write,
  output logic [18:0]          mem_addr,
  output logic [18:0]          mem_wdata,
  input  logic [18:0]          mem_rdata
);

  localparam int            CW        = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);
  localparam logic [1:0]    LAST_ID   = 2'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            lock_q, lock_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic [18:0]     req_rdata_q, req_rdata_d;
  logic            busy_q, busy_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_write_q, mem_write_d;
  logic [18:0]     mem_addr_q, mem_addr_d;
  logic [18:0]     mem_wdata_q, mem_wdata_d;

  logic            grant_found;
  logic [1:0]      grant_idx;
  logic            sel_write;
  logic            sel_lock;
  logic [18:0]     sel_addr;
  logic [18:0]     sel_wdata;
  logic [1:0]      next_ptr;

  // Search from ptr upward first, then wrap to the indices below ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (2'(i) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (2'(i) < ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = 2'(i);
      end
    end
  end

  // Pick out the fields of the requester that would win this cycle.
  always_comb begin
    sel_write = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_write = req_write[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*19 +: 19];
        sel_wdata = req_wdata[i*19 +: 19];
      end
    end
  end

  // The requester after the current grant, wrapping at the last real index.
  always_comb begin
    next_ptr = (gnt_id_q == LAST_ID) ? 2'd0 : gnt_id_q + 2'd1;
  end

  // Transaction sequencing plus the pointer/lock bookkeeping done in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    lock_cnt_d  = lock_cnt_q;
    lock_d      = lock_q;
    req_done_d  = '0;
    req_rdata_d = req_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          gnt_id_d    = grant_idx;
          lock_d      = sel_lock;
          mem_write_d = sel_write;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_valid_d = 1'b1;
          if (grant_idx != gnt_id_q) begin
            lock_cnt_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_valid_d = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (!mem_write_q) begin
          req_rdata_d = mem_rdata;
        end
        for (int i = 0; i < NREQ; i++) begin
          req_done_d[i] = (gnt_id_q == 2'(i));
        end
        if (lock_q && (lock_cnt_q != LOCK_LAST)) begin
          ptr_d      = gnt_id_q;
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          ptr_d      = next_ptr;
          lock_cnt_d = '0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // All state and every output is registered; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      lock_cnt_q  <= '0;
      lock_q      <= 1'b0;
      req_done_q  <= '0;
      req_rdata_q <= '0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_q      <= lock_d;
      req_done_q  <= req_done_d;
      req_rdata_q <= req_rdata_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_rdata = req_rdata_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents driven from transaction queues, a
// simple memory responder, and a transaction-level model of the grant rules.
module tb_mem_arbiter;

  localparam int N    = 3;
  localparam int MAXL = 8;

  typedef struct { logic wr; logic lk; logic [18:0] addr; logic [18:0] wdata; } txn_t;
  typedef struct { int cycle; logic [1:0] gnt; logic wr; logic [18:0] addr; logic [18:0] wdata; } issue_t;
  typedef struct { int id; int cycle; logic [2:0] vec; logic [18:0] rdata; logic [1:0] gnt; int cnt; } done_t;
  typedef struct { int id; logic wr; logic [18:0] addr; logic [18:0] wdata; logic [18:0] rdata; int cnt; } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_write, req_lock;
  logic [N*19-1:0] req_addr, req_wdata;
  logic [N-1:0]    req_done;
  logic [18:0]     req_rdata;
  logic [1:0]      gnt_id;
  logic            busy, mem_valid, mem_write;
  logic [18:0]     mem_addr, mem_wdata;
  logic [18:0]     mem_rdata = 19'h0;

  int vectors    = 0;
  int miscompares = 0;

  txn_t   q  [N][$];
  txn_t   pq [N][$];
  issue_t issue_log[$];
  done_t  done_log[$];
  exp_t   exp_q[$];

  logic [18:0] resp_mem [int];
  logic [18:0] ref_mem  [int];
  int          m_ptr, m_cnt, m_prev;
  logic [18:0] m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(N), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .gnt_id(gnt_id), .busy(busy),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory answers a read with data one cycle after the strobe cycle.
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) resp_mem[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= resp_mem.exists(int'(mem_addr)) ? resp_mem[int'(mem_addr)] : 19'h0;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic txn_t mk(input logic wr, input logic lk, input logic [18:0] a, input logic [18:0] d);
    txn_t t;
    t.wr = wr; t.lk = lk; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic update_drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = 1'b1; req_write[i] = q[i][0].wr; req_lock[i] = q[i][0].lk;
        req_addr[i*19 +: 19] = q[i][0].addr; req_wdata[i*19 +: 19] = q[i][0].wdata;
      end else begin
        req_valid[i] = 1'b0; req_write[i] = 1'b0; req_lock[i] = 1'b0;
        req_addr[i*19 +: 19] = '0; req_wdata[i*19 +: 19] = '0;
      end
    end
  endtask

  task automatic add_txn(input int id, input txn_t t);
    q[id].push_back(t);
    pq[id].push_back(t);
  endtask

  task automatic preload(input logic [18:0] a, input logic [18:0] d);
    resp_mem[int'(a)] = d;
    ref_mem[int'(a)]  = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_prev = 0; m_rdata = 19'h0;
    exp_q.delete();
    for (int i = 0; i < N; i++) pq[i].delete();
  endtask

  // Serve pending transactions in round-robin order from m_ptr, applying the lock budget.
  task automatic predict();
    txn_t t;
    exp_t e;
    int   g;
    for (int n = 0; n < 1000; n++) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pq[(m_ptr + k) % N].size() > 0) g = (m_ptr + k) % N;
      end
      if (g < 0) break;
      t = pq[g].pop_front();
      if (t.wr) ref_mem[int'(t.addr)] = t.wdata;
      else m_rdata = ref_mem.exists(int'(t.addr)) ? ref_mem[int'(t.addr)] : 19'h0;
      if (g != m_prev) m_cnt = 0;
      if (t.lk && m_cnt < MAXL - 1) begin
        m_ptr = g; m_cnt = m_cnt + 1;
      end else begin
        m_ptr = (g + 1) % N; m_cnt = 0;
      end
      m_prev = g;
      e.id = g; e.wr = t.wr; e.addr = t.addr; e.wdata = t.wdata; e.rdata = m_rdata; e.cnt = m_cnt;
      exp_q.push_back(e);
    end
  endtask

  // Step the clock, logging strobes and completions, retiring finished requests.
  task automatic run_engine(input int budget, input int inject_at, input int inject_id,
                            input txn_t inject_txn, output bit timed_out);
    int id;
    issue_log.delete(); done_log.delete(); timed_out = 1'b1;
    update_drive();
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (c == inject_at) begin q[inject_id].push_back(inject_txn); update_drive(); end
      if (mem_valid) issue_log.push_back('{cycle: c, gnt: gnt_id, wr: mem_write, addr: mem_addr, wdata: mem_wdata});
      if (req_done != '0) begin
        id = -1;
        for (int i = 0; i < N; i++) if (req_done[i]) id = (id == -1) ? i : -2;
        done_log.push_back('{id: id, cycle: c, vec: req_done, rdata: req_rdata, gnt: gnt_id, cnt: int'(dut.lock_cnt_q)});
        if (id >= 0 && q[id].size() > 0) begin q[id].delete(0); update_drive(); end
      end
      if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && !busy && c > inject_at) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      for (int i = 0; i < N; i++) q[i].delete();
      update_drive();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    update_drive();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    update_drive();
    @(posedge clk); #1;
    vectors++; if (req_done  !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_req_done: got %b, want 000", req_done); end
    vectors++; if (req_rdata !== 19'h0)  begin miscompares++; $display("[TB] FAIL reset_req_rdata: got %h, want 0", req_rdata); end
    vectors++; if (gnt_id    !== 2'd0)   begin miscompares++; $display("[TB] FAIL reset_gnt_id: got %0d, want 0", gnt_id); end
    vectors++; if (busy      !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
    vectors++; if (mem_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_mem_valid: got %b, want 0", mem_valid); end
    vectors++; if (mem_write !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_mem_write: got %b, want 0", mem_write); end
    vectors++; if (mem_addr  !== 19'h0)  begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h, want 0", mem_addr); end
    vectors++; if (mem_wdata !== 19'h0)  begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h, want 0", mem_wdata); end
    #3 rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_no_req: got busy=%b mem_valid=%b, want 0 0", busy, mem_valid); end
  endtask

  task automatic test_single_read();
    bit to;
    do_reset(); model_reset();
    preload(19'h00100, 19'h1ABCD);
    add_txn(1, mk(1'b0, 1'b0, 19'h00100, 19'h0));
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL single_timeout: got timeout, want completion"); end
    vectors++; if (issue_log.size() !== 1) begin miscompares++; $display("[TB] FAIL single_strobes: got %0d, want 1", issue_log.size()); end
    if (issue_log.size() >= 1) begin
      vectors++; if (issue_log[0].cycle !== 1) begin miscompares++; $display("[TB] FAIL single_issue_cycle: got %0d, want 1", issue_log[0].cycle); end
      vectors++; if (issue_log[0].addr !== 19'h00100 || issue_log[0].wr !== 1'b0) begin miscompares++; $display("[TB] FAIL single_issue_fields: got addr=%h wr=%b, want 00100 0", issue_log[0].addr, issue_log[0].wr); end
    end
    vectors++; if (done_log.size() !== 1) begin miscompares++; $display("[TB] FAIL single_dones: got %0d, want 1", done_log.size()); end
    if (done_log.size() >= 1) begin
      vectors++; if (done_log[0].cycle !== 3) begin miscompares++; $display("[TB] FAIL single_done_cycle: got %0d, want 3", done_log[0].cycle); end
      vectors++; if (done_log[0].vec !== 3'b010) begin miscompares++; $display("[TB] FAIL single_done_vec: got %b, want 010", done_log[0].vec); end
      vectors++; if (done_log[0].rdata !== 19'h1ABCD) begin miscompares++; $display("[TB] FAIL single_rdata: got %h, want 1abcd", done_log[0].rdata); end
      vectors++; if (done_log[0].gnt !== 2'd1) begin miscompares++; $display("[TB] FAIL single_gnt: got %0d, want 1", done_log[0].gnt); end
    end
  endtask

  task automatic test_round_robin();
    bit to;
    int pat [6] = '{0, 1, 2, 0, 1, 2};
    do_reset(); model_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        add_txn(i, mk(1'($urandom_range(0, 1)), 1'b0, {16'h0A00, 3'($urandom_range(0, 7))}, 19'($urandom)));
    predict();
    run_engine(60, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (to || done_log.size() !== 6) begin miscompares++; $display("[TB] FAIL rr_count: got %0d dones timeout=%0b, want 6", done_log.size(), to); end
    vectors++; if (issue_log.size() !== 6) begin miscompares++; $display("[TB] FAIL rr_strobes: got %0d, want 6", issue_log.size()); end
    for (int i = 0; i < done_log.size() && i < 6; i++) begin
      vectors++; if (done_log[i].id !== pat[i]) begin miscompares++; $display("[TB] FAIL rr_order[%0d]: got %0d, want %0d", i, done_log[i].id, pat[i]); end
      vectors++; if (done_log[i].rdata !== exp_q[i].rdata) begin miscompares++; $display("[TB] FAIL rr_rdata[%0d]: got %h, want %h", i, done_log[i].rdata, exp_q[i].rdata); end
      if (i > 0) begin
        vectors++; if (done_log[i].cycle - done_log[i-1].cycle !== 4) begin miscompares++; $display("[TB] FAIL rr_spacing[%0d]: got %0d, want 4", i, done_log[i].cycle - done_log[i-1].cycle); end
      end
      if (i < issue_log.size()) begin
        vectors++; if (issue_log[i].addr !== exp_q[i].addr || issue_log[i].wr !== exp_q[i].wr || (exp_q[i].wr && issue_log[i].wdata !== exp_q[i].wdata)) begin
          miscompares++; $display("[TB] FAIL rr_issue[%0d]: got addr=%h wr=%b wd=%h, want addr=%h wr=%b wd=%h", i, issue_log[i].addr, issue_log[i].wr, issue_log[i].wdata, exp_q[i].addr, exp_q[i].wr, exp_q[i].wdata);
        end
      end
    end
  endtask

  task automatic test_write_pass();
    bit to;
    logic [18:0] held;
    held = m_rdata;
    add_txn(2, mk(1'b1, 1'b0, 19'h7FFFF, 19'h7FFFF));
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (to || issue_log.size() !== 1 || done_log.size() !== 1) begin miscompares++; $display("[TB] FAIL wr_count: got %0d strobes %0d dones, want 1 1", issue_log.size(), done_log.size()); end
    if (issue_log.size() >= 1) begin
      vectors++; if (issue_log[0].wr !== 1'b1 || issue_log[0].addr !== 19'h7FFFF || issue_log[0].wdata !== 19'h7FFFF) begin
        miscompares++; $display("[TB] FAIL wr_fields: got wr=%b addr=%h wd=%h, want 1 7ffff 7ffff", issue_log[0].wr, issue_log[0].addr, issue_log[0].wdata);
      end
    end
    if (done_log.size() >= 1) begin
      vectors++; if (done_log[0].rdata !== held || done_log[0].vec !== 3'b100) begin miscompares++; $display("[TB] FAIL wr_done: got vec=%b rdata=%h, want 100 %h", done_log[0].vec, done_log[0].rdata, held); end
    end
    vectors++; if (req_rdata !== held) begin miscompares++; $display("[TB] FAIL wr_rdata_hold: got %h, want %h", req_rdata, held); end
    add_txn(0, mk(1'b0, 1'b0, 19'h7FFFF, 19'h0));
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (done_log.size() < 1 || done_log[0].rdata !== 19'h7FFFF) begin miscompares++; $display("[TB] FAIL wr_readback: got %0d dones rdata=%h, want 7ffff", done_log.size(), req_rdata); end
  endtask

  task automatic test_lock_bound();
    bit to;
    int pat [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    do_reset(); model_reset();
    add_txn(0, mk(1'b0, 1'b0, 19'h00010, 19'h0));
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      preload(19'h01000 + 19'(k), 19'($urandom));
      add_txn(1, mk(1'b0, 1'b1, 19'h01000 + 19'(k), 19'h0));
    end
    for (int k = 0; k < 10; k++) add_txn(0, mk(1'b0, 1'b0, 19'h02000 + 19'(k), 19'h0));
    predict();
    run_engine(4 * 22 + 20, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (to || done_log.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL lock_count: got %0d dones timeout=%0b, want %0d", done_log.size(), to, exp_q.size()); end
    for (int i = 0; i < done_log.size() && i < exp_q.size(); i++) begin
      if (i < 13) begin
        vectors++; if (done_log[i].id !== pat[i]) begin miscompares++; $display("[TB] FAIL lock_order[%0d]: got %0d, want %0d", i, done_log[i].id, pat[i]); end
      end
      vectors++; if (done_log[i].id !== exp_q[i].id || done_log[i].rdata !== exp_q[i].rdata) begin
        miscompares++; $display("[TB] FAIL lock_model[%0d]: got id=%0d rdata=%h, want id=%0d rdata=%h", i, done_log[i].id, done_log[i].rdata, exp_q[i].id, exp_q[i].rdata);
      end
      vectors++; if (done_log[i].cnt !== exp_q[i].cnt) begin miscompares++; $display("[TB] FAIL lock_cnt[%0d]: got %0d, want %0d", i, done_log[i].cnt, exp_q[i].cnt); end
    end
    if (done_log.size() > 7) begin
      vectors++; if (done_log[7].cnt !== 0) begin miscompares++; $display("[TB] FAIL lock_release_cnt: got %0d, want 0", done_log[7].cnt); end
    end
  endtask

  task automatic test_reset_mid_op();
    bit to;
    txn_t t1, t2;
    do_reset(); model_reset();
    add_txn(1, mk(1'b0, 1'b0, 19'h00300, 19'h0));
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    t1 = mk(1'b0, 1'b0, 19'h00301, 19'h0);
    t2 = mk(1'b0, 1'b0, 19'h00302, 19'h0);
    preload(19'h00301, 19'h11111);
    preload(19'h00302, 19'h22222);
    q[1].push_back(t1); q[2].push_back(t2);
    update_drive();
    @(posedge clk); #1;
    vectors++; if (mem_valid !== 1'b1 || gnt_id !== 2'd2) begin miscompares++; $display("[TB] FAIL mid_pre_issue: got mem_valid=%b gnt=%0d, want 1 2", mem_valid, gnt_id); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_drop: got mem_valid=%b busy=%b, want 0 0", mem_valid, busy); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++; if (req_done !== 3'b000 || mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_no_done[%0d]: got done=%b mem_valid=%b, want 000 0", c, req_done, mem_valid); end
    end
    #3 rst_n = 1'b1;
    model_reset();
    pq[1].push_back(t1); pq[2].push_back(t2);
    predict();
    run_engine(40, -1, 0, mk(0, 0, 0, 0), to);
    vectors++; if (to || done_log.size() !== 2) begin miscompares++; $display("[TB] FAIL mid_count: got %0d dones timeout=%0b, want 2", done_log.size(), to); end
    for (int i = 0; i < done_log.size() && i < exp_q.size(); i++) begin
      vectors++; if (done_log[i].id !== exp_q[i].id || done_log[i].rdata !== exp_q[i].rdata) begin
        miscompares++; $display("[TB] FAIL mid_regrant[%0d]: got id=%0d rdata=%h, want id=%0d rdata=%h", i, done_log[i].id, done_log[i].rdata, exp_q[i].id, exp_q[i].rdata);
      end
    end
  endtask

  task automatic test_late_request();
    bit to;
    txn_t late;
    do_reset(); model_reset();
    preload(19'h00500, 19'h05555);
    preload(19'h00600, 19'h06666);
    add_txn(2, mk(1'b0, 1'b0, 19'h00500, 19'h0));
    predict();
    late = mk(1'b0, 1'b0, 19'h00600, 19'h0);
    pq[0].push_back(late);
    predict();
    run_engine(40, 2, 0, late, to);
    vectors++; if (to || issue_log.size() !== 2 || done_log.size() !== 2) begin miscompares++; $display("[TB] FAIL late_count: got %0d strobes %0d dones, want 2 2", issue_log.size(), done_log.size()); end
    if (issue_log.size() >= 2) begin
      vectors++; if (issue_log[0].cycle !== 1 || issue_log[1].cycle !== 5) begin miscompares++; $display("[TB] FAIL late_issue_cycles: got %0d %0d, want 1 5", issue_log[0].cycle, issue_log[1].cycle); end
    end
    for (int i = 0; i < done_log.size() && i < exp_q.size(); i++) begin
      vectors++; if (done_log[i].id !== exp_q[i].id || done_log[i].rdata !== exp_q[i].rdata || done_log[i].cycle !== 3 + 4 * i) begin
        miscompares++; $display("[TB] FAIL late_done[%0d]: got id=%0d rdata=%h cyc=%0d, want id=%0d rdata=%h cyc=%0d", i, done_log[i].id, done_log[i].rdata, done_log[i].cycle, exp_q[i].id, exp_q[i].rdata, 3 + 4 * i);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int total;
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      total = 0;
      for (int i = 0; i < N; i++) begin
        int cnt = $urandom_range(0, 10);
        for (int k = 0; k < cnt; k++) begin
          add_txn(i, mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                        {16'h0B00, 3'($urandom_range(0, 7))}, 19'($urandom)));
          total++;
        end
      end
      predict();
      run_engine(4 * total + 20, -1, 0, mk(0, 0, 0, 0), to);
      vectors++; if (to || done_log.size() !== total || issue_log.size() !== total) begin
        miscompares++; $display("[TB] FAIL b2b_count[%0d]: got %0d dones %0d strobes timeout=%0b, want %0d", r, done_log.size(), issue_log.size(), to, total);
      end
      for (int i = 0; i < done_log.size() && i < exp_q.size(); i++) begin
        vectors++; if (done_log[i].id !== exp_q[i].id || done_log[i].rdata !== exp_q[i].rdata || done_log[i].cnt !== exp_q[i].cnt) begin
          miscompares++; $display("[TB] FAIL b2b_done[%0d.%0d]: got id=%0d rdata=%h cnt=%0d, want id=%0d rdata=%h cnt=%0d", r, i, done_log[i].id, done_log[i].rdata, done_log[i].cnt, exp_q[i].id, exp_q[i].rdata, exp_q[i].cnt);
        end
        if (i > 0) begin
          vectors++; if (done_log[i].cycle - done_log[i-1].cycle !== 4) begin miscompares++; $display("[TB] FAIL b2b_spacing[%0d.%0d]: got %0d, want 4", r, i, done_log[i].cycle - done_log[i-1].cycle); end
        end
        if (i < issue_log.size()) begin
          vectors++; if (issue_log[i].addr !== exp_q[i].addr || issue_log[i].wr !== exp_q[i].wr || (exp_q[i].wr && issue_log[i].wdata !== exp_q[i].wdata)) begin
            miscompares++; $display("[TB] FAIL b2b_issue[%0d.%0d]: got addr=%h wr=%b, want addr=%h wr=%b", r, i, issue_log[i].addr, issue_log[i].wr, exp_q[i].addr, exp_q[i].wr);
          end
        end
      end
    end
  endtask

  // Run every scenario in order, then report the totals.
  initial begin
    $display("[TB] mem_arbiter bench starting");
    test_reset();
    test_single_read();
    test_write_pass();
    test_round_robin();
    test_lock_bound();
    test_reset_mid_op();
    test_late_request();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Round-robin arbiter that shares the single 19-bit memory port between up to four bus masters (CPU load/store unit, FFT accelerator, crypto accelerator).
- Each transaction is captured, issued to memory, and completed with a `req_done` pulse before the next arbitration.
- A lock input lets an accelerator hold the port for short bursts, bounded by `MAX_LOCK` to prevent starvation.

## Interface

Parameters:
- `NREQ`, default 3: number of requesters, legal range 2..4.
- `MAX_LOCK`, default 8: maximum consecutive locked grants to one requester (matches the 8-point FFT frame).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input NREQ: per-requester request. Held high with stable fields until the matching `req_done`.
- `req_write` input NREQ: 1 = write, 0 = read.
- `req_lock` input NREQ: keep priority on this requester after its grant.
- `req_addr` input NREQ*19: flattened addresses; requester i at bits [19i+18:19i].
- `req_wdata` input NREQ*19: flattened write data, same packing as `req_addr`.
- `req_done` output NREQ: one-cycle completion pulse to the granted requester.
- `req_rdata` output 19: read data; valid in the `req_done` cycle of a read, shared by all requesters.
- `gnt_id` output 2: index of the current or last granted requester.
- `busy` output 1: high in every state except IDLE.
- `mem_valid` output 1: memory request strobe.
- `mem_write` output 1: memory write enable.
- `mem_addr` output 19: memory address.
- `mem_wdata` output 19: memory write data.
- `mem_rdata` input 19: memory read data, valid the cycle after the `mem_valid` cycle.

## Operation

FSM states: IDLE, ISSUE, RESP, DONE. All outputs are registered.

- **IDLE**
  - If any `req_valid` is set, pick grant g as the first set bit searching from `ptr` upward, wrapping at NREQ-1 back to 0.
  - Latch g into `gnt_id`.
  - Drive `mem_addr`/`mem_wdata`/`mem_write` from requester g and set `mem_valid`=1.
  - Go to ISSUE. With no request, stay in IDLE and leave the `mem_*` fields unchanged.
- **ISSUE**: `mem_valid`=1 during this cycle. Clear it at the end of the cycle and go to RESP.
- **RESP**
  - If the transaction is a read, capture `mem_rdata` into `req_rdata`.
  - Set `req_done[g]`=1, update `ptr` and `lock_cnt`, and go to DONE.
- **DONE**: `req_done[g]` is high for exactly this cycle. Clear it and go to IDLE.

Pointer and lock rules, evaluated with the `req_lock[g]` value latched at grant:
- lock=0: `ptr` <= (g+1) mod NREQ, `lock_cnt` <= 0.
- lock=1 and `lock_cnt` < MAX_LOCK-1: `ptr` <= g, `lock_cnt` <= `lock_cnt`+1.
- lock=1 and `lock_cnt` == MAX_LOCK-1: `ptr` <= (g+1) mod NREQ, `lock_cnt` <= 0 (forced release).
- A grant to a different requester than the previous one starts counting from 0.

Width rules:
- `ptr` and `gnt_id` are 2 bits; `lock_cnt` is $clog2(MAX_LOCK) bits.
- Address and data pass through unmodified at 19 bits; there is no arithmetic on them.

Boundary and error conditions:
- Requests are sampled only in IDLE. Requests arriving in other states wait.
- A requester dropping `req_valid` after grant is a protocol violation. The latched transaction still completes and `req_done` still pulses.
- `req_valid` bits at indices ≥ NREQ do not exist; `ptr` never exceeds NREQ-1.
- `req_rdata` holds its last value after a write or while idle.

Reset, asynchronous and valid at any time including mid-transaction:
- State=IDLE, `mem_valid`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- `req_done`=0, `req_rdata`=0, `gnt_id`=0, `busy`=0, `ptr`=0, `lock_cnt`=0.
- An in-flight transaction is abandoned and no `req_done` is issued.

## Timing

- Request high in IDLE during cycle 0:
  - cycle 1: `mem_valid`=1 (ISSUE)
  - cycle 2: RESP
  - cycle 3: `req_done`=1 with `req_rdata` (DONE)
  - cycle 4: IDLE, sampling again
- Earliest next `mem_valid` is cycle 5, giving a sustained throughput of 1 transaction per 4 cycles.
- Requesters drop or change their request on the edge ending the `req_done` cycle. The IDLE cycle that follows samples the updated request, so a finished request is never reissued.
- `mem_valid` is high for exactly one cycle per transaction.

## Test plan

- **Single read.** Reset, preload mem[0x00100]=0x1ABCD, requester 1 reads 0x00100.
  - Required: `mem_valid` in cycle 1 with `mem_addr`=0x00100 and `mem_write`=0.
  - Required: `req_done`=3'b010 in cycle 3 with `req_rdata`=0x1ABCD, `gnt_id`=1.
- **Round robin.** All three requesters hold `req_valid` with lock=0.
  - Required grant order after reset: 0, 1, 2, 0, 1, 2.
  - Required: each `req_done` exactly 4 cycles apart.
- **Write pass-through.** Requester 2 writes 0x7FFFF to address 0x7FFFF.
  - Required: `mem_write`=1, `mem_addr`=0x7FFFF, `mem_wdata`=0x7FFFF.
  - Required: `req_rdata` unchanged.
- **Lock bound.** Requester 1 issues 12 locked reads while requester 0 requests continuously.
  - Required grant order: 1×8, then 0, then 1×4.
  - Required: `lock_cnt` returns to 0 after the forced release.
- **Reset mid-op.** Assert `rst_n`=0 during ISSUE.
  - Required: `mem_valid` falls immediately (asynchronously), with no `req_done`.
  - Required: after release, the held request is re-granted from `ptr`=0.
- **Late request.** Requester 0 raises `req_valid` during RESP of requester 2's transaction.
  - Required: requester 0 is granted in the IDLE cycle following DONE, not earlier.
